sfx_mixer: RTL and testbench

Event-driven sound-effect sequencer and final audio mixer for the game's single-bit speaker path. It sits directly downstream of the background-music tone generator and consumes its square-wave `beep` as `music_in`. On one-cycle game events (flap, score, hit) it plays a short fixed note sequence as a square wave. While an effect plays, the effect overrides the music; otherwise the music passes through. The registered result drives the speaker pin.

---
 rtl/sfx_pkg.sv | 51 +++++
 rtl/sfx_tone_gen.sv | 48 ++++
 rtl/sfx_mixer.sv | 163 ++++++++++++++++
 tb/tb_sfx_mixer.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/sfx_pkg.sv
// Shared types, note constants and step tables for the sound-effect sequencer.
// The effect enum order doubles as the priority order (NONE lowest, HIT highest).
package sfx_pkg;

  typedef enum logic [1:0] {
    EFF_NONE  = 2'd0,
    EFF_FLAP  = 2'd1,
    EFF_SCORE = 2'd2,
    EFF_HIT   = 2'd3
  } sfx_eff_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TONE = 2'd1,
    ST_GAP  = 2'd2
  } sfx_state_e;

  localparam int HP_W   = 18;
  localparam int STEP_W = 2;

  localparam int unsigned F_196  = 196;
  localparam int unsigned F_262  = 262;
  localparam int unsigned F_392  = 392;
  localparam int unsigned F_1047 = 1047;
  localparam int unsigned F_1319 = 1319;
  localparam int unsigned F_1568 = 1568;

  function automatic logic [STEP_W-1:0] eff_steps(input sfx_eff_e eff);
    case (eff)
      EFF_FLAP:  return 2'd2;
      EFF_SCORE: return 2'd3;
      EFF_HIT:   return 2'd3;
      default:   return 2'd0;
    endcase
  endfunction

  function automatic int unsigned step_freq(input sfx_eff_e eff, input logic [STEP_W-1:0] step);
    case (eff)
      EFF_FLAP:  return (step == 2'd0) ? F_1319 : F_1568;
      EFF_SCORE: return (step == 2'd0) ? F_1047 : ((step == 2'd1) ? F_1319 : F_1568);
      EFF_HIT:   return (step == 2'd0) ? F_392 : ((step == 2'd1) ? F_262 : F_196);
      default:   return 0;
    endcase
  endfunction

  function automatic logic [HP_W-1:0] hp_of(input int unsigned clk_hz, input int unsigned freq);
    if (freq == 0) return '0;
    return HP_W'(clk_hz / (2 * freq));
  endfunction

endpackage

// File: rtl/sfx_tone_gen.sv
// Half-period counter and square register for one note step.
// sq presents the value the square register takes at the coming edge, so the mixer's output flop is the only stage.
module sfx_tone_gen
  import sfx_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            restart,
  input  logic            enable,
  input  logic [HP_W-1:0] half_period,
  output logic            sq
);

  logic [HP_W-1:0] r_cnt;
  logic [HP_W-1:0] w_cnt_nxt;
  logic            r_sq;
  logic            w_sq_nxt;

  always_comb begin
    w_cnt_nxt = r_cnt;
    w_sq_nxt  = r_sq;
    if (restart) begin
      w_cnt_nxt = '0;
      w_sq_nxt  = 1'b1;
    end else if (!enable) begin
      w_cnt_nxt = '0;
      w_sq_nxt  = 1'b0;
    end else if (r_cnt == half_period - HP_W'(1)) begin
      w_cnt_nxt = '0;
      w_sq_nxt  = ~r_sq;
    end else begin
      w_cnt_nxt = r_cnt + HP_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_sq  <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_sq  <= w_sq_nxt;
    end
  end

  assign sq = w_sq_nxt;

endmodule

// File: rtl/sfx_mixer.sv
// Event-driven effect sequencer with priority arbitration and final speaker mix.
//   state | meaning
//   IDLE  | no effect, music passes through
//   TONE  | current step's note is sounding for TONE_CYCLES
//   GAP   | silence between steps for GAP_CYCLES
module sfx_mixer
  import sfx_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 50_000_000,
  parameter int unsigned TONE_CYCLES = 2_500_000,
  parameter int unsigned GAP_CYCLES  = 500_000
)
(
  input  logic clk,
  input  logic rst,
  input  logic music_in,
  input  logic ev_flap,
  input  logic ev_score,
  input  logic ev_hit,
  input  logic mute,
  output logic audio_out,
  output logic sfx_active
);

  localparam int unsigned CNT_MAX = (TONE_CYCLES > GAP_CYCLES) ? TONE_CYCLES : GAP_CYCLES;
  localparam int CNT_W = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] TONE_TC = CNT_W'(TONE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_TC  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  localparam logic [HP_W-1:0] HP_196  = hp_of(CLK_HZ, F_196);
  localparam logic [HP_W-1:0] HP_262  = hp_of(CLK_HZ, F_262);
  localparam logic [HP_W-1:0] HP_392  = hp_of(CLK_HZ, F_392);
  localparam logic [HP_W-1:0] HP_1047 = hp_of(CLK_HZ, F_1047);
  localparam logic [HP_W-1:0] HP_1319 = hp_of(CLK_HZ, F_1319);
  localparam logic [HP_W-1:0] HP_1568 = hp_of(CLK_HZ, F_1568);

  sfx_state_e        r_state, w_state_nxt;
  sfx_eff_e          r_eff, w_eff_nxt, w_req;
  logic [STEP_W-1:0] r_step, w_step_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic              w_accept;
  logic              w_restart;
  logic              w_enable;
  logic              w_last_step;
  logic              w_sq;
  logic              w_active_nxt;
  int unsigned       w_freq;
  logic [HP_W-1:0]   w_hp;
  logic              r_audio;

  always_comb begin
    w_req = EFF_NONE;
    if (ev_hit)        w_req = EFF_HIT;
    else if (ev_score) w_req = EFF_SCORE;
    else if (ev_flap)  w_req = EFF_FLAP;
  end

  // Equal priority restarts too, so a retrigger of the same effect begins again at step 0.
  assign w_accept    = (w_req != EFF_NONE) && (w_req >= r_eff);
  assign w_last_step = (r_step == eff_steps(r_eff) - 2'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_eff   <= EFF_NONE;
      r_step  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_eff   <= w_eff_nxt;
      r_step  <= w_step_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_eff_nxt   = r_eff;
    w_step_nxt  = r_step;
    w_cnt_nxt   = r_cnt + CNT_W'(1);
    w_restart   = 1'b0;
    if (w_accept) begin
      w_state_nxt = ST_TONE;
      w_eff_nxt   = w_req;
      w_step_nxt  = '0;
      w_cnt_nxt   = '0;
      w_restart   = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_cnt_nxt = '0;
        end
        ST_TONE: begin
          if (r_cnt == TONE_TC) begin
            w_cnt_nxt = '0;
            if (w_last_step) begin
              w_state_nxt = ST_IDLE;
              w_eff_nxt   = EFF_NONE;
              w_step_nxt  = '0;
            end else if (GAP_CYCLES > 0) begin
              w_state_nxt = ST_GAP;
            end else begin
              w_step_nxt = r_step + 2'd1;
              w_restart  = 1'b1;
            end
          end
        end
        ST_GAP: begin
          if (r_cnt == GAP_TC) begin
            w_state_nxt = ST_TONE;
            w_step_nxt  = r_step + 2'd1;
            w_cnt_nxt   = '0;
            w_restart   = 1'b1;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_eff_nxt   = EFF_NONE;
          w_step_nxt  = '0;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Note lookup uses the upcoming step so a restart loads the right half-period.
  always_comb begin
    w_freq = step_freq(w_eff_nxt, w_step_nxt);
    case (w_freq)
      F_196:   w_hp = HP_196;
      F_262:   w_hp = HP_262;
      F_392:   w_hp = HP_392;
      F_1047:  w_hp = HP_1047;
      F_1319:  w_hp = HP_1319;
      F_1568:  w_hp = HP_1568;
      default: w_hp = '0;
    endcase
  end

  assign w_enable     = (w_state_nxt == ST_TONE);
  assign w_active_nxt = (w_state_nxt != ST_IDLE);

  sfx_tone_gen u_tone_gen (
    .clk         (clk),
    .rst         (rst),
    .restart     (w_restart),
    .enable      (w_enable),
    .half_period (w_hp),
    .sq          (w_sq)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_audio <= 1'b0;
    end else begin
      r_audio <= mute ? 1'b0 : (w_active_nxt ? w_sq : music_in);
    end
  end

  assign audio_out  = r_audio;
  assign sfx_active = (r_state != ST_IDLE);

endmodule

// File: tb/tb_sfx_mixer.sv
// Randomized bench for sfx_mixer against an elapsed-time model of the effect schedule.
// Two instances share stimulus: one with a gap between steps and one without.
module tb_sfx_mixer;

  localparam int CLK_HZ = 100_000;
  localparam int TONE   = 200;
  localparam int GAP    = 40;

  logic clk = 1'b0;
  logic rst, music_in, ev_flap, ev_score, ev_hit, mute;
  logic audio_a, act_a, audio_b, act_b;

  sfx_mixer #(.CLK_HZ(CLK_HZ), .TONE_CYCLES(TONE), .GAP_CYCLES(GAP)) u_dut (
    .clk(clk), .rst(rst), .music_in(music_in), .ev_flap(ev_flap), .ev_score(ev_score),
    .ev_hit(ev_hit), .mute(mute), .audio_out(audio_a), .sfx_active(act_a)
  );

  sfx_mixer #(.CLK_HZ(CLK_HZ), .TONE_CYCLES(TONE), .GAP_CYCLES(0)) u_dut_nogap (
    .clk(clk), .rst(rst), .music_in(music_in), .ev_flap(ev_flap), .ev_score(ev_score),
    .ev_hit(ev_hit), .mute(mute), .audio_out(audio_b), .sfx_active(act_b)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int act_cnt = 0;
  int m_eff [2];
  int m_k   [2];
  int m_gap [2];
  logic e_act   [2];
  logic e_audio [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int n_steps(input int e);
    return (e == 1) ? 2 : 3;
  endfunction

  function automatic int hp(input int e, input int s);
    case (e)
      1:       return (s == 0) ? 37 : 31;
      2:       return (s == 0) ? 47 : ((s == 1) ? 37 : 31);
      default: return (s == 0) ? 127 : ((s == 1) ? 190 : 255);
    endcase
  endfunction

  function automatic int total(input int e, input int g);
    return n_steps(e) * TONE + (n_steps(e) - 1) * g;
  endfunction

  function automatic logic model_sq(input int e, input int k, input int g);
    int seg, s, r;
    seg = TONE + g;
    s   = k / seg;
    r   = k % seg;
    if (r >= TONE) return 1'b0;
    return ((r / hp(e, s)) % 2) == 0;
  endfunction

  task automatic model_step();
    int req;
    req = ev_hit ? 3 : (ev_score ? 2 : (ev_flap ? 1 : 0));
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_eff[d] = 0;
        m_k[d]   = 0;
      end else if (req != 0 && req >= m_eff[d]) begin
        m_eff[d] = req;
        m_k[d]   = 0;
      end else if (m_eff[d] != 0) begin
        m_k[d]++;
        if (m_k[d] >= total(m_eff[d], m_gap[d])) m_eff[d] = 0;
      end
      e_act[d] = (m_eff[d] != 0);
      if (rst || mute)   e_audio[d] = 1'b0;
      else if (e_act[d]) e_audio[d] = model_sq(m_eff[d], m_k[d], m_gap[d]);
      else               e_audio[d] = music_in;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    if (act_a) act_cnt++;
    check("active_gap", act_a, e_act[0]);
    check("audio_gap", audio_a, e_audio[0]);
    check("active_nogap", act_b, e_act[1]);
    check("audio_nogap", audio_b, e_audio[1]);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 7) == 0) music_in = ~music_in;
      tick();
    end
  endtask

  task automatic pulse(input logic f, input logic s, input logic h);
    ev_flap = f; ev_score = s; ev_hit = h;
    tick();
    ev_flap = 1'b0; ev_score = 1'b0; ev_hit = 1'b0;
  endtask

  initial begin
    m_eff = '{0, 0}; m_k = '{0, 0}; m_gap = '{GAP, 0};
    rst = 1'b1; music_in = 1'b0; ev_flap = 1'b0; ev_score = 1'b0; ev_hit = 1'b0; mute = 1'b0;
    for (int i = 0; i < 6; i++) begin
      music_in = ~music_in;
      tick();
    end
    rst = 1'b0;
    run(20);

    act_cnt = 0;
    pulse(1'b1, 1'b0, 1'b0);
    run(460);
    check("flap_active_len", act_cnt, 440);

    act_cnt = 0;
    pulse(1'b1, 1'b0, 1'b1);
    run(700);
    check("hit_active_len", act_cnt, 680);

    pulse(1'b0, 1'b0, 1'b1);
    run(99);
    pulse(1'b1, 1'b0, 1'b0);
    run(620);

    pulse(1'b0, 1'b1, 1'b0);
    run(99);
    act_cnt = 0;
    pulse(1'b0, 1'b0, 1'b1);
    run(700);
    check("score_to_hit_len", act_cnt, 680);

    pulse(1'b1, 1'b0, 1'b0);
    run(50);
    pulse(1'b1, 1'b0, 1'b0);
    run(500);

    mute = 1'b1;
    pulse(1'b0, 1'b1, 1'b0);
    run(300);
    mute = 1'b0;
    run(420);

    pulse(1'b0, 1'b1, 1'b0);
    run(299);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    run(300);

    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0) music_in = ~music_in;
      if ($urandom_range(0, 299) == 0) mute = ~mute;
      ev_flap  = ($urandom_range(0, 149) == 0);
      ev_score = ($urandom_range(0, 249) == 0);
      ev_hit   = ($urandom_range(0, 399) == 0);
      rst      = ($urandom_range(0, 1499) == 0);
      tick();
      ev_flap = 1'b0; ev_score = 1'b0; ev_hit = 1'b0; rst = 1'b0;
    end
    mute = 1'b0;
    run(800);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
